// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants and FSM state type for the 7-segment frame capture
package seg7_pkg;

    // Active-low segment patterns, bit order g..a = [6:0]
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PRESENT = 2'd3
    } cap_state_e;

endpackage

// File: rtl/seg7_glyph_to_nibble.sv
// rtl/seg7_glyph_to_nibble.sv - combinational 7-segment pattern to hex nibble decoder
//   seg    : active-low segment pattern, g..a = [6:0]
//   nibble : decoded hex value (0 when the pattern is not a known glyph)
//   bad    : 1 when the pattern is not in the glyph table (blank included)
module seg7_glyph_to_nibble
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       bad
);

    always_comb begin
        nibble = 4'h0;
        bad    = 1'b0;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_frame_capture.sv
// rtl/seg7_frame_capture.sv - samples a multiplexed 7-segment bus and emits decoded frames
//   clk, rst          : clock, asynchronous active-high reset
//   seg_in, dig_in    : active-low segment lines and digit strobes from the display
//   out_value/out_bad : captured frame, nibble i at [4i+3:4i], bad flag i at [i]
//   out_valid/ready   : frame handshake
//   overrun           : sticky, a completed frame was dropped while out_valid was held
module seg7_frame_capture
    import seg7_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dig_in,
    output logic [4*NDIG-1:0] out_value,
    output logic [NDIG-1:0]   out_bad,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0]        seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_p_q, seg_p_d;
    logic [NDIG-1:0]   dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d, dig_p_q, dig_p_d;
    cap_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic [NDIG-1:0]   lock_q, lock_d;
    logic [4*NDIG-1:0] slot_value_q, slot_value_d;
    logic [NDIG-1:0]   slot_bad_q, slot_bad_d;
    logic [4*NDIG-1:0] out_value_q, out_value_d;
    logic [NDIG-1:0]   out_bad_q, out_bad_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;

    logic [NDIG-1:0]   act;
    logic              one_hot;
    logic              changed;
    logic [3:0]        nibble;
    logic              bad;

    seg7_glyph_to_nibble u_decode (
        .seg    (seg_s2_q),
        .nibble (nibble),
        .bad    (bad)
    );

    always_comb begin
        seg_s1_d = seg_in;
        seg_s2_d = seg_s1_q;
        seg_p_d  = seg_s2_q;
        dig_s1_d = dig_in;
        dig_s2_d = dig_s1_q;
        dig_p_d  = dig_s2_q;

        // act is the active-high strobe; when one_hot it doubles as the slot select mask
        act     = ~dig_s2_q;
        one_hot = ($countones(act) == 1);
        changed = (seg_s2_q != seg_p_q) || (dig_s2_q != dig_p_q);

        state_d      = state_q;
        cnt_d        = cnt_q;
        seen_d       = seen_q;
        lock_d       = lock_q & act;   // a lock releases once its strobe deasserts
        slot_value_d = slot_value_q;
        slot_bad_d   = slot_bad_q;
        out_value_d  = out_value_q;
        out_bad_d    = out_bad_q;
        out_valid_d  = out_valid_q && !out_ready;
        overrun_d    = overrun_q;

        case (state_q)
            ST_WAIT: begin
                cnt_d = 8'd0;
                if (one_hot && ((lock_q & act) == '0)) begin
                    state_d = ST_SETTLE;
                    // the sample seen here already counts when it matches the previous one
                    cnt_d   = changed ? 8'd0 : 8'd1;
                end
            end
            ST_SETTLE: begin
                if (changed || !one_hot) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_CAPTURE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_WAIT;
                cnt_d   = 8'd0;
                // a change landing in this cycle means the settled pattern is already gone
                if (!changed && one_hot) begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (act[i]) begin
                            slot_value_d[4*i +: 4] = nibble;
                            slot_bad_d[i]          = bad;
                        end
                    end
                    seen_d = seen_q | act;
                    lock_d = lock_q | act;
                    if (&seen_d) begin
                        state_d = ST_PRESENT;
                        // a same-edge handshake frees the output register for the new frame
                        if (!out_valid_q || out_ready) begin
                            out_value_d = slot_value_d;
                            out_bad_d   = slot_bad_d;
                            out_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            ST_PRESENT: begin
                // out_valid is held by its own register, so capture resumes immediately
                seen_d  = '0;
                state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q     <= '1;
            seg_s2_q     <= '1;
            seg_p_q      <= '1;
            dig_s1_q     <= '1;
            dig_s2_q     <= '1;
            dig_p_q      <= '1;
            state_q      <= ST_WAIT;
            cnt_q        <= 8'd0;
            seen_q       <= '0;
            lock_q       <= '0;
            slot_value_q <= '0;
            slot_bad_q   <= '0;
            out_value_q  <= '0;
            out_bad_q    <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            seg_s1_q     <= seg_s1_d;
            seg_s2_q     <= seg_s2_d;
            seg_p_q      <= seg_p_d;
            dig_s1_q     <= dig_s1_d;
            dig_s2_q     <= dig_s2_d;
            dig_p_q      <= dig_p_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            lock_q       <= lock_d;
            slot_value_q <= slot_value_d;
            slot_bad_q   <= slot_bad_d;
            out_value_q  <= out_value_d;
            out_bad_q    <= out_bad_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_value = out_value_q;
    assign out_bad   = out_bad_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_frame_capture.sv
// tb/tb_seg7_frame_capture.sv - self-checking bench for seg7_frame_capture
module tb_seg7_frame_capture;
    import seg7_pkg::*;

    localparam int NDIG = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        seg_in;
    logic [NDIG-1:0]   dig_in;
    logic [4*NDIG-1:0] out_value;
    logic [NDIG-1:0]   out_bad;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;

    always #5 clk = ~clk;

    seg7_frame_capture #(.NDIG(NDIG), .STABLE_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dig_in    (dig_in),
        .out_value (out_value),
        .out_bad   (out_bad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    int   tests  = 0;
    int   fails  = 0;
    int   pulses = 0;
    logic valid_prev = 1'b0;

    // count rising edges of out_valid, sampled between clock edges
    always @(posedge clk) begin
        #2;
        if (out_valid && !valid_prev) pulses++;
        valid_prev = out_valid;
    end

    typedef struct {
        string       name;
        logic [6:0]  seg [NDIG];
        logic [15:0] exp_value;
        logic [3:0]  exp_bad;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_digit(input int d, input logic [6:0] seg, input int cycles);
        dig_in    = '1;
        dig_in[d] = 1'b0;
        seg_in    = seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        dig_in = '1;
        seg_in = SEG_BLANK;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        run_digit(0, s0, 20);
        run_digit(1, s1, 20);
        run_digit(2, s2, 20);
        run_digit(3, s3, 20);
        idle(5);
    endtask

    initial begin
        int p0;

        vecs[0].name = "hex_3A0F";
        vecs[0].seg  = '{SEG_3, SEG_A, SEG_0, SEG_F};
        vecs[0].exp_value = 16'hF0A3; vecs[0].exp_bad = 4'b0000;
        vecs[1].name = "blank_d1";
        vecs[1].seg  = '{SEG_8, SEG_BLANK, SEG_8, SEG_8};
        vecs[1].exp_value = 16'h8808; vecs[1].exp_bad = 4'b0010;
        vecs[2].name = "hex_7bd9";
        vecs[2].seg  = '{SEG_7, SEG_B, SEG_D, SEG_9};
        vecs[2].exp_value = 16'h9DB7; vecs[2].exp_bad = 4'b0000;
        vecs[3].name = "bad_ends";
        vecs[3].seg  = '{7'b0111111, SEG_E, SEG_C, 7'b1111110};
        vecs[3].exp_value = 16'h0CE0; vecs[3].exp_bad = 4'b1001;
        vecs[4].name = "hex_6542";
        vecs[4].seg  = '{SEG_6, SEG_5, SEG_4, SEG_2};
        vecs[4].exp_value = 16'h2456; vecs[4].exp_bad = 4'b0000;

        rst       = 1'b1;
        seg_in    = SEG_BLANK;
        dig_in    = '1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_value",   32'(out_value), 32'h0);
        check("reset_bad",     32'(out_bad),   32'h0);
        check("reset_valid",   32'(out_valid), 32'h0);
        check("reset_overrun", 32'(overrun),   32'h0);
        rst = 1'b0;
        idle(3);

        // table-driven frames with out_ready held high
        for (int v = 0; v < 5; v++) begin
            p0 = pulses;
            run_frame(vecs[v].seg[0], vecs[v].seg[1], vecs[v].seg[2], vecs[v].seg[3]);
            check({vecs[v].name, "_pulses"}, 32'(pulses - p0), 32'd1);
            check({vecs[v].name, "_value"},  32'(out_value),    32'(vecs[v].exp_value));
            check({vecs[v].name, "_bad"},    32'(out_bad),      32'(vecs[v].exp_bad));
        end

        // toggling segments never settle; steady pattern captures 11 cycles after last change
        p0 = pulses;
        run_digit(0, SEG_1, 20);
        run_digit(1, SEG_2, 20);
        run_digit(2, SEG_3, 20);
        for (int k = 0; k < 8; k++) run_digit(3, (k % 2 == 0) ? SEG_1 : SEG_2, 5);
        check("toggle_no_capture", 32'(pulses - p0), 32'd0);
        run_digit(3, SEG_4, 11);
        check("toggle_not_yet", 32'(out_valid), 32'd0);
        run_digit(3, SEG_4, 1);
        check("toggle_latency", 32'(out_valid), 32'd1);
        check("toggle_value",   32'(out_value), 32'h4321);
        run_digit(3, SEG_4, 8);
        idle(5);

        // overrun: second frame is dropped while the first is still held
        out_ready = 1'b0;
        run_frame(SEG_9, SEG_8, SEG_7, SEG_6);
        check("ovr_first_valid",   32'(out_valid), 32'd1);
        check("ovr_first_overrun", 32'(overrun),   32'd0);
        run_frame(SEG_0, SEG_1, SEG_2, SEG_3);
        check("ovr_held_value", 32'(out_value), 32'h6789);
        check("ovr_held_valid", 32'(out_valid), 32'd1);
        check("ovr_sticky",     32'(overrun),   32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("ovr_ready_drop", 32'(out_valid), 32'd0);
        check("ovr_after_pop",  32'(out_value), 32'h6789);
        idle(3);

        // two strobes active at once must never capture
        p0 = pulses;
        dig_in = 4'b1100;
        seg_in = SEG_1;
        repeat (30) @(negedge clk);
        idle(5);
        run_digit(2, SEG_2, 20);
        idle(5);
        check("two_active_no_frame", 32'(pulses - p0), 32'd0);

        // reset mid-frame discards the partial frame and the sticky overrun
        run_digit(0, SEG_1, 20);
        run_digit(1, SEG_2, 20);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_value",   32'(out_value), 32'h0);
        check("rst_mid_bad",     32'(out_bad),   32'h0);
        check("rst_mid_valid",   32'(out_valid), 32'h0);
        check("rst_mid_overrun", 32'(overrun),   32'h0);
        rst = 1'b0;
        idle(3);
        p0 = pulses;
        run_digit(2, SEG_C, 20);
        run_digit(3, SEG_D, 20);
        idle(5);
        check("rst_partial_no_frame", 32'(pulses - p0), 32'd0);
        run_digit(0, SEG_E, 20);
        run_digit(1, SEG_B, 20);
        idle(5);
        check("rst_full_frame", 32'(pulses - p0), 32'd1);
        check("rst_full_value", 32'(out_value),    32'hDCBE);
        check("rst_full_bad",   32'(out_bad),      32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
